// File: rtl/hht_pkg.sv
// Shared types and constants for the HHT CSR memory responder.
package hht_pkg;
    localparam int DW = 32;

    typedef enum logic [1:0] {ROW = 2'd0, COL = 2'd1, VAL = 2'd2, VEC = 2'd3} region_e;

    localparam logic [4:0] CODE_ROW = 5'd15;
    localparam logic [4:0] CODE_COL = 5'd6;
    localparam logic [4:0] CODE_VAL = 5'd9;
    localparam logic [4:0] CODE_VEC = 5'd8;

    localparam logic [DW-1:0] DEFAULT_DATA = 32'd99999;

    typedef struct packed {
        logic    hit;
        region_e region;
    } lookup_t;

    // Maps an engine register code to the region whose base it asks for.
    function automatic lookup_t code_lookup(input logic [4:0] code);
        lookup_t l;
        l.hit    = 1'b1;
        l.region = ROW;
        case (code)
            CODE_ROW: l.region = ROW;
            CODE_COL: l.region = COL;
            CODE_VAL: l.region = VAL;
            CODE_VEC: l.region = VEC;
            default:  l.hit = 1'b0;
        endcase
        return l;
    endfunction
endpackage

// File: rtl/hht_region_bank.sv
// One CSR region: two asynchronous read ports and one synchronous write port.
module hht_region_bank
    import hht_pkg::*;
#(
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DW-1:0]          wdata,
    input  logic [1:0][AW-1:0]     raddr,
    output logic [1:0][DW-1:0]     rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Reads are sampled by the caller at the same edge that commits the write,
    // so a colliding read sees the old word.
    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata[0] = mem[raddr[0]];
    assign rdata[1] = mem[raddr[1]];
endmodule

// File: rtl/hht_csr_mem_responder.sv
// Serves the HHT engine's two read ports from four CSR regions and answers base lookups.
module hht_csr_mem_responder
    import hht_pkg::*;
#(
    parameter int            REGION_DEPTH = 256,
    parameter int            LAT          = 1,
    parameter logic [DW-1:0] DEFAULT_DATA = hht_pkg::DEFAULT_DATA
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          ld_we,
    input  logic [DW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          req1,
    input  logic [DW-1:0] addr1,
    input  logic          req2,
    input  logic [DW-1:0] addr2,
    output logic [DW-1:0] dataIn1,
    output logic          vld1,
    output logic [DW-1:0] dataIn2,
    output logic          vld2,
    input  logic [4:0]    regaddr1,
    input  logic [4:0]    regaddr2,
    output logic [DW-1:0] base_dat_a,
    output logic [DW-1:0] base_dat_b,
    output logic          err
);
    localparam int            AW      = $clog2(REGION_DEPTH);
    localparam logic [DW-1:0] DEPTH_W = DW'(REGION_DEPTH);

    logic [3:0][DW-1:0]          base;
    logic [1:0]                  req;
    logic [2:0][DW-1:0]          dec_addr;
    logic [2:0]                  dec_hit;
    region_e                     dec_rgn [3];
    logic [2:0][3:0][AW-1:0]     dec_off;
    logic [3:0][1:0][DW-1:0]     bank_rd;
    logic [1:0][DW-1:0]          rd;
    logic [1:0][LAT:1]           vld_pipe;
    logic [1:0][LAT:1][DW-1:0]   dat_pipe;
    lookup_t                     la, lb;

    assign req      = {req2, req1};
    assign dec_addr = {ld_addr, addr2, addr1};

    // Decoders 0/1 serve the read ports, 2 serves preload. Scanning from the
    // top region down lets the lowest matching index win on overlap.
    always_comb begin
        logic [DW-1:0] diff;
        diff = '0;
        for (int q = 0; q < 3; q++) begin
            dec_hit[q] = 1'b0;
            dec_rgn[q] = ROW;
            for (int r = 3; r >= 0; r--) begin
                diff          = dec_addr[q] - base[r];
                dec_off[q][r] = diff[AW-1:0];
                if (dec_addr[q] >= base[r] && diff < DEPTH_W) begin
                    dec_hit[q] = 1'b1;
                    dec_rgn[q] = region_e'(2'(r));
                end
            end
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_bank
        hht_region_bank #(.DEPTH(REGION_DEPTH)) u_bank (
            .Clk   (Clk),
            .we    (ld_we && dec_hit[2] && (dec_rgn[2] == 2'(r))),
            .waddr (dec_off[2][r]),
            .wdata (ld_data),
            .raddr ({dec_off[1][r], dec_off[0][r]}),
            .rdata (bank_rd[r])
        );
    end

    always_comb begin
        for (int p = 0; p < 2; p++)
            rd[p] = dec_hit[p] ? bank_rd[dec_rgn[p]][p] : DEFAULT_DATA;
    end

    assign la = code_lookup(regaddr1);
    assign lb = code_lookup(regaddr2);

    // Data stages only advance on a valid beat, so the output holds between responses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_pipe   <= '0;
            dat_pipe   <= '0;
            base       <= '0;
            base_dat_a <= '0;
            base_dat_b <= '0;
            err        <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                vld_pipe[p][1] <= req[p];
                if (req[p]) dat_pipe[p][1] <= rd[p];
                for (int s = 2; s <= LAT; s++) begin
                    vld_pipe[p][s] <= vld_pipe[p][s-1];
                    if (vld_pipe[p][s-1]) dat_pipe[p][s] <= dat_pipe[p][s-1];
                end
            end
            err <= err | (|(req & ~dec_hit[1:0])) | (ld_we & ~dec_hit[2]);
            if (cfg_we) base[cfg_sel] <= cfg_wdata;
            if (la.hit) base_dat_a <= base[la.region];
            if (lb.hit) base_dat_b <= base[lb.region];
        end
    end

    assign vld1    = vld_pipe[0][LAT];
    assign dataIn1 = dat_pipe[0][LAT];
    assign vld2    = vld_pipe[1][LAT];
    assign dataIn2 = dat_pipe[1][LAT];
endmodule
